mem_access_unit: RTL and testbench

//  Memory-stage load/store unit, directly downstream of the execute-stage ALU.
//  - Takes the ALU result (the effective address) and the store data from the EX/MEM register.
//  - Runs one request/acknowledge transaction on the data-memory bus.
//  - Stalls the pipeline while the transaction is outstanding.
//  - Returns the load result, byte/half-selected and extended, for writeback.

---
 rtl/mem_access_unit.sv | 244 ++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit.
// Takes the effective address and store data from EX/MEM and runs one
// request/acknowledge transaction on the data-memory bus. The pipeline is
// stalled while the transaction is outstanding. The load result comes back
// lane-selected and extended, ready for writeback.
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    // Timer only has to count up to TIMEOUT-1.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Width/alignment legality of a request; stores have no unsigned forms.
    function automatic logic access_illegal(input logic [2:0] f3,
                                            input logic       we,
                                            input logic [1:0] off);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = off[0];
            3'b010:  bad = (off != 2'b00);
            3'b100:  bad = we;
            3'b101:  bad = we;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte enables for the addressed lanes (used for loads and stores alike).
    function automatic logic [3:0] lane_be(input logic [2:0] f3,
                                           input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data replicated across all lanes so the byte enables pick the lane.
    function automatic logic [31:0] lane_wdata(input logic [2:0]  f3,
                                               input logic [31:0] wd);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{wd[7:0]}};
            2'b01:   w = {2{wd[15:0]}};
            2'b10:   w = wd;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // Select the addressed byte/half from the read word and extend it.
    function automatic logic [31:0] load_format(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rd[{off, 3'b000} +: 8];
        h = rd[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = rd;
            3'b100:  r = {24'h00_0000, b};
            3'b101:  r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    state_t           state_q,     state_d;
    logic             bus_req_q,   bus_req_d;
    logic             bus_we_q,    bus_we_d;
    logic [31:0]      bus_addr_q,  bus_addr_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic [3:0]       bus_be_q,    bus_be_d;
    logic [31:0]      rdata_q,     rdata_d;
    logic [1:0]       offset_q,    offset_d;
    logic [TW-1:0]    timer_q,     timer_d;
    logic             err_q,       err_d;
    logic             we_q,        we_d;
    logic [2:0]       funct3_q,    funct3_d;

    logic             stall_s;
    logic             misalign_s;
    logic             illegal_s;

    assign illegal_s = access_illegal(Funct3M, MemWriteM, ALUResultM[1:0]);

    // Next-state, request capture, response capture and the combinational handshake.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        rdata_d     = rdata_q;
        offset_d    = offset_q;
        timer_d     = timer_q;
        err_d       = err_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        stall_s     = 1'b0;
        misalign_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (MemReqM) begin
                    if (illegal_s) begin
                        // Rejected before touching the bus; pipeline moves on.
                        misalign_s = 1'b1;
                    end else begin
                        stall_s     = 1'b1;
                        state_d     = ST_BUS;
                        bus_req_d   = 1'b1;
                        bus_we_d    = MemWriteM;
                        bus_addr_d  = {ALUResultM[31:2], 2'b00};
                        bus_be_d    = lane_be(Funct3M, ALUResultM[1:0]);
                        bus_wdata_d = MemWriteM ? lane_wdata(Funct3M, WriteDataM)
                                                : 32'h0000_0000;
                        offset_d    = ALUResultM[1:0];
                        timer_d     = {TW{1'b0}};
                        we_d        = MemWriteM;
                        funct3_d    = Funct3M;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                stall_s = 1'b1;
                if (bus_ack) begin
                    // An ack in the final timer cycle still counts as success.
                    rdata_d = bus_rdata;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    rdata_d = 32'h0000_0000;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
                if (state_d == ST_DONE) begin
                    // Bus signals return to zero as soon as the request retires.
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = 32'h0000_0000;
                    bus_wdata_d = 32'h0000_0000;
                    bus_be_d    = 4'b0000;
                end else begin
                    bus_req_d   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                bus_req_d   = 1'b0;
                bus_we_d    = 1'b0;
                bus_addr_d  = 32'h0000_0000;
                bus_wdata_d = 32'h0000_0000;
                bus_be_d    = 4'b0000;
            end
        endcase
    end

    // State and bus/response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_wdata_q <= 32'h0000_0000;
            bus_be_q    <= 4'b0000;
            rdata_q     <= 32'h0000_0000;
            offset_q    <= 2'b00;
            timer_q     <= {TW{1'b0}};
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            rdata_q     <= rdata_d;
            offset_q    <= offset_d;
            timer_q     <= timer_d;
            err_q       <= err_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
        end
    end

    assign StallM    = stall_s;
    assign MisalignM = misalign_s;
    assign BusErrM   = (state_q == ST_DONE) && err_q;
    assign ReadDataM = ((state_q == ST_DONE) && !we_q)
                       ? load_format(funct3_q, offset_q, rdata_q)
                       : 32'h0000_0000;

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: the driver queues expected bus requests and
// responses; a negedge monitor pops and compares them as the DUT shows them.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemReqM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [2:0]  Funct3M = 3'b000;
    logic [31:0] ALUResultM = 32'h0;
    logic [31:0] WriteDataM = 32'h0;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        MisalignM;
    logic        BusErrM;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    logic        ack_r = 1'b0;
    logic        late_ack = 1'b0;
    logic [31:0] rdata_r = 32'h0;
    int          ack_delay = -1;
    logic [31:0] cur_rdata = 32'h0;
    int          rcnt = 0;

    int vectors = 0;
    int miscompares = 0;

    assign bus_ack   = ack_r | late_ack;
    assign bus_rdata = rdata_r;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .MemReqM(MemReqM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .StallM(StallM), .ReadDataM(ReadDataM), .MisalignM(MisalignM),
        .BusErrM(BusErrM), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        misal;
        logic [31:0] rdata;
        logic        err;
        int          stalls;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } busx_t;

    resp_t resp_q[$];
    busx_t bus_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic logic ref_illegal(input logic we, input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'd0:    return 1'b0;
            3'd1:    return (a % 2) != 0;
            3'd2:    return (a % 4) != 0;
            3'd4:    return we;
            3'd5:    return we;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        if (f3 == 3'd0 || f3 == 3'd4) return 4'(1 << off);
        if (f3 == 3'd1 || f3 == 3'd5) return 4'(3 << off);
        return 4'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 3'd0) return (wd % 256) * 32'h0101_0101;
        if (f3 == 3'd1) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        int off;
        off = int'(a % 4);
        b = (rd >> (8 * off)) % 256;
        h = (rd >> (16 * (off / 2))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rd;
        endcase
    endfunction

    // ---------------- memory responder ----------------
    // Acks after ack_delay BUS cycles; a negative delay never acks.
    always @(negedge clk) begin
        if (bus_req) begin
            if (ack_delay >= 0 && rcnt == ack_delay) begin
                ack_r   = 1'b1;
                rdata_r = cur_rdata;
            end else begin
                ack_r   = 1'b0;
                rdata_r = $urandom;
            end
            rcnt++;
        end else begin
            ack_r = 1'b0;
            rcnt  = 0;
        end
    end

    // ---------------- monitor ----------------
    logic prev_stall = 1'b0;
    logic prev_req = 1'b0;
    int   stall_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            prev_req   = 1'b0;
            stall_cnt  = 0;
        end else begin
            if (bus_req && !prev_req) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_bus_req", 32'(bus_req), 32'h0);
                end else begin
                    busx_t e;
                    e = bus_q.pop_front();
                    chk("bus_addr", bus_addr, e.addr);
                    chk("bus_we", 32'(bus_we), 32'(e.we));
                    chk("bus_be", 32'(bus_be), 32'(e.be));
                    if (e.we) chk("bus_wdata", bus_wdata, e.wdata);
                end
            end
            if (StallM) stall_cnt++;
            if (MisalignM) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_misalign", 32'(MisalignM), 32'h0);
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    chk("misalign_expected", 32'(MisalignM), 32'(r.misal));
                    chk("misalign_stall", 32'(StallM), 32'h0);
                end
            end
            if (prev_stall && !StallM) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_done", 32'(StallM), 32'h1);
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    chk("done_not_misalign", 32'(r.misal), 32'h0);
                    chk("ReadDataM", ReadDataM, r.rdata);
                    chk("BusErrM", 32'(BusErrM), 32'(r.err));
                    chk("stall_cycles", 32'(stall_cnt), 32'(r.stalls));
                    chk("done_bus_req", 32'(bus_req), 32'h0);
                end
                stall_cnt = 0;
            end
            prev_stall = StallM;
            prev_req   = bus_req;
        end
    end

    // ---------------- driver ----------------
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int delay, input logic [31:0] rd);
        resp_t r;
        busx_t b;
        int n;
        r.misal  = ref_illegal(we, f3, a);
        r.err    = (delay < 0) && !r.misal;
        r.stalls = (delay < 0) ? TO + 1 : delay + 2;
        r.rdata  = (r.misal || we || delay < 0) ? 32'h0 : ref_load(f3, a, rd);
        resp_q.push_back(r);
        if (!r.misal) begin
            b.addr  = a - (a % 4);
            b.we    = we;
            b.be    = ref_be(f3, a);
            b.wdata = ref_wdata(f3, wd);
            bus_q.push_back(b);
        end
        ack_delay  = delay;
        cur_rdata  = rd;
        MemReqM    = 1'b1;
        MemWriteM  = we;
        Funct3M    = f3;
        ALUResultM = a;
        WriteDataM = wd;
        @(negedge clk);
        n = 0;
        while (StallM && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("stall_timeout", 32'(StallM), 32'h0);
        @(posedge clk);
        #1;
        MemReqM = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [2:0] pick_f3(input int k);
        case (k)
            0: return 3'd0;
            1: return 3'd1;
            2: return 3'd2;
            3: return 3'd4;
            4: return 3'd5;
            5: return 3'd3;
            6: return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_bus_req", 32'(bus_req), 32'h0);
        chk("rst_StallM", 32'(StallM), 32'h0);
        chk("rst_ReadDataM", ReadDataM, 32'h0);
        chk("rst_BusErrM", 32'(BusErrM), 32'h0);
        chk("rst_MisalignM", 32'(MisalignM), 32'h0);
        @(posedge clk);
        #1;

        access(1'b0, 3'd2, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
        access(1'b0, 3'd0, 32'h103, 32'h0, 0, 32'h80FF_1234);
        access(1'b0, 3'd4, 32'h103, 32'h0, 0, 32'h80FF_1234);
        access(1'b0, 3'd1, 32'h102, 32'h0, 0, 32'h80FF_1234);
        access(1'b1, 3'd0, 32'h201, 32'h0000_00AB, 0, 32'h0);
        access(1'b1, 3'd1, 32'h202, 32'h1234_ABCD, 1, 32'h0);
        access(1'b0, 3'd2, 32'h102, 32'h0, 0, 32'h0);
        access(1'b0, 3'd3, 32'h100, 32'h0, 0, 32'h0);
        access(1'b1, 3'd4, 32'h100, 32'h0, 0, 32'h0);
        access(1'b0, 3'd2, 32'h300, 32'h0, -1, 32'h1111_2222);
        access(1'b0, 3'd2, 32'h304, 32'h0, TO - 1, 32'h5555_AAAA);
        access(1'b1, 3'd2, 32'h308, 32'hCAFE_F00D, -1, 32'h0);

        // Reset in the middle of a bus transaction; a late ack must be ignored.
        begin
            busx_t b;
            b.addr = 32'h400; b.we = 1'b0; b.be = 4'hF; b.wdata = 32'h0;
            bus_q.push_back(b);
            ack_delay  = -1;
            MemReqM    = 1'b1;
            MemWriteM  = 1'b0;
            Funct3M    = 3'd2;
            ALUResultM = 32'h400;
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            rst     = 1'b1;
            MemReqM = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            chk("mid_rst_bus_req", 32'(bus_req), 32'h0);
            chk("mid_rst_StallM", 32'(StallM), 32'h0);
            late_ack = 1'b1;
            @(posedge clk);
            #1;
            late_ack = 1'b0;
            @(negedge clk);
            chk("late_ack_bus_req", 32'(bus_req), 32'h0);
            chk("late_ack_StallM", 32'(StallM), 32'h0);
            chk("late_ack_BusErrM", 32'(BusErrM), 32'h0);
            chk("late_ack_ReadDataM", ReadDataM, 32'h0);
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f3;
            logic        we;
            int          d;
            f3 = pick_f3(($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 7));
            we = $urandom_range(0, 1) == 1;
            d  = $urandom_range(0, TO);
            if (d == TO) d = -1;
            access(we, f3, {$urandom_range(0, 32'hFFFF), 2'b00} + 32'($urandom_range(0, 3)),
                   $urandom, d, $urandom);
        end

        repeat (4) @(posedge clk);
        chk("resp_queue_empty", 32'(resp_q.size()), 32'h0);
        chk("bus_queue_empty", 32'(bus_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
